// File: rtl/logic_exec_unit_pkg.sv
// Shared op codes and FSM state encodings for the logic
// execution unit and its ALU stage.
package logic_exec_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_e;

endpackage

// File: rtl/logic_exec_unit_logic_32b.sv
// Bitwise logic unit: AND / OR / XOR / NOR selected by a
// 2-bit op code.
module logic_32b
  import logic_exec_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op_e'(sel))
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_exec_unit.sv
// Four-phase logic execution unit: capture, read operands,
// execute, write back, with a direct register load port.
module logic_exec_unit
  import logic_exec_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_rd
);

  state_e            state;
  logic [1:0]        op;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] regs [REG_CNT];

  assign cmd_ready = (state == S_IDLE);
  assign ld_ready  = (state == S_IDLE);

  logic_32b #(.W(DATA_W)) u_lu (
    .sel (op),
    .a   (opa),
    .b   (opb),
    .y   (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op        <= '0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      opa       <= '0;
      opb       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // a same-cycle load lands before READ samples regs
          if (ld_en) regs[ld_addr] <= ld_data;
          if (cmd_valid) begin
            op    <= cmd_op;
            rs    <= cmd_rs;
            rt    <= cmd_rt;
            rd    <= cmd_rd;
            state <= S_READ;
          end
        end
        S_READ: begin
          opa   <= regs[rs];
          opb   <= regs[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_data  <= alu_y;
          res_rd    <= rd;
          res_valid <= 1'b1;
          state     <= S_WB;
        end
        S_WB: begin
          regs[rd] <= res_data;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_exec_unit.sv
// Randomized and directed bench for logic_exec_unit against
// a behavioural register-file model.
module tb_logic_exec_unit;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rs = '0;
  logic [AW-1:0] cmd_rt = '0;
  logic [AW-1:0] cmd_rd = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic_exec_unit #(.DATA_W(DW), .REG_CNT(RC), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_rd    (cmd_rd),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_rd    (res_rd)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lfun(input logic [1:0] o,
                                         input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // model: a command is busy for 3 edges after acceptance
  logic [DW-1:0] m_reg [RC];
  logic [DW-1:0] m_res;
  logic [AW-1:0] m_rd;
  int            m_age = -1;
  bit            m_init = 0;
  logic          e_valid = 1'b0;
  logic [DW-1:0] e_data = '0;
  logic [AW-1:0] e_rd = '0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RC; i++) m_reg[i] = '0;
      m_age = -1;
      e_valid = 1'b0;
      e_data = '0;
      e_rd = '0;
      m_init = 1;
    end else if (m_init) begin
      e_valid = 1'b0;
      if (m_age < 0) begin
        if (ld_en) m_reg[ld_addr] = ld_data;
        if (cmd_valid) begin
          m_res = lfun(cmd_op, m_reg[cmd_rs], m_reg[cmd_rt]);
          m_rd = cmd_rd;
          m_age = 0;
        end
      end else begin
        m_age++;
        if (m_age == 2) begin
          e_valid = 1'b1;
          e_data = m_res;
          e_rd = m_rd;
        end
        if (m_age == 3) begin
          m_reg[m_rd] = m_res;
          m_age = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_age < 0});
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, m_age < 0});
      chk("res_valid", {31'b0, res_valid}, {31'b0, e_valid});
      chk("res_data", res_data, e_data);
      chk("res_rd", {29'b0, res_rd}, {29'b0, e_rd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] o, input logic [AW-1:0] s,
                         input logic [AW-1:0] t, input logic [AW-1:0] d,
                         output logic [DW-1:0] rdat,
                         output logic [AW-1:0] rrd, output int lat);
    bit got;
    cmd_valid = 1'b1;
    cmd_op = o;
    cmd_rs = s;
    cmd_rt = t;
    cmd_rd = d;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    got = 0;
    rdat = 'x;
    rrd = 'x;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) begin
        got = 1;
        rdat = res_data;
        rrd = res_rd;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL res_valid_timeout got=none want=pulse t=%0t", $time);
    end
    tick();
  endtask

  task automatic readback(input logic [AW-1:0] r, input logic [DW-1:0] exp,
                          input string nm);
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int l;
    run_cmd(2'b01, r, r, r, d, a, l);
    chk(nm, d, exp);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int l;
    int nv;
    int nr;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    tick();

    load(3'd1, 32'h6);
    load(3'd2, 32'hC);
    run_cmd(2'b00, 3'd1, 3'd2, 3'd3, d, a, l);
    chk("and_data", d, 32'h4);
    chk("and_rd", {29'b0, a}, 32'd3);
    chk("latency", l, 32'd3);
    readback(3'd3, 32'h4, "r3_wb");
    run_cmd(2'b01, 3'd1, 3'd2, 3'd3, d, a, l);
    chk("or_data", d, 32'hE);
    run_cmd(2'b10, 3'd1, 3'd2, 3'd3, d, a, l);
    chk("xor_data", d, 32'hA);
    run_cmd(2'b11, 3'd1, 3'd2, 3'd3, d, a, l);
    chk("nor_data", d, 32'hFFFF_FFF1);

    run_cmd(2'b01, 3'd1, 3'd2, 3'd1, d, a, l);
    chk("chain1", d, 32'hE);
    run_cmd(2'b10, 3'd1, 3'd2, 3'd4, d, a, l);
    chk("chain2", d, 32'h2);
    readback(3'd1, 32'hE, "r1_chain");
    readback(3'd4, 32'h2, "r4_chain");

    // load attempted while the unit is in EXEC
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_rs = 3'd1;
    cmd_rt = 3'd2;
    cmd_rd = 3'd6;
    tick();
    cmd_valid = 1'b0;
    tick();
    ld_en = 1'b1;
    ld_addr = 3'd5;
    ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0;
    tick();
    readback(3'd5, 32'h0, "ld_busy_ignored");
    load(3'd5, 32'hDEAD_BEEF);
    readback(3'd5, 32'hDEAD_BEEF, "ld_idle");

    // cmd_valid held high for 12 edges
    nv = 0;
    nr = 0;
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_rs = 3'd1;
    cmd_rt = 3'd2;
    cmd_rd = 3'd6;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (res_valid) nv++;
      if (cmd_ready) nr++;
    end
    cmd_valid = 1'b0;
    chk("hold_pulses", nv, 32'd3);
    chk("hold_ready", nr, 32'd3);
    tick();

    // reset while in EXEC aborts the command
    load(3'd1, 32'h6);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_rs = 3'd1;
    cmd_rt = 3'd1;
    cmd_rd = 3'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      if (res_valid) nv++;
    end
    chk("abort_no_pulse", nv, 32'd0);
    tick();
    readback(3'd2, 32'h0, "abort_no_wb");

    for (int i = 0; i < 600; i++) begin
      tick();
      reset = ($urandom_range(0, 79) == 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_op = 2'($urandom);
      cmd_rs = 3'($urandom);
      cmd_rt = 3'($urandom);
      cmd_rd = 3'($urandom);
      ld_en = ($urandom_range(0, 2) == 0);
      ld_addr = 3'($urandom);
      ld_data = $urandom;
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    ld_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
